// File: rtl/score_display_ctrl_pkg.sv
// Shared types and helpers for the score display controller.
package score_display_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StDecode
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Largest value displayable on n decimal digits: 9, 99, ..., 999999.
  function automatic int unsigned max_value(input int unsigned n);
    int unsigned m;
    m = 1;
    for (int unsigned i = 0; i < n; i++) begin
      m = m * 10;
    end
    return m - 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/HexTo7Segment.sv
// Hex nibble to 7-segment decoder, segment order {g,f,e,d,c,b,a}.
module HexTo7Segment #(
  parameter bit INVERT_OUTPUT = 1'b0
) (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  logic [6:0] w_seg;

  always_comb begin
    w_seg = 7'h00;
    case (i_hex)
      4'h0:    w_seg = 7'h3F;
      4'h1:    w_seg = 7'h06;
      4'h2:    w_seg = 7'h5B;
      4'h3:    w_seg = 7'h4F;
      4'h4:    w_seg = 7'h66;
      4'h5:    w_seg = 7'h6D;
      4'h6:    w_seg = 7'h7D;
      4'h7:    w_seg = 7'h07;
      4'h8:    w_seg = 7'h7F;
      4'h9:    w_seg = 7'h6F;
      4'hA:    w_seg = 7'h77;
      4'hB:    w_seg = 7'h7C;
      4'hC:    w_seg = 7'h39;
      4'hD:    w_seg = 7'h5E;
      4'hE:    w_seg = 7'h79;
      default: w_seg = 7'h71;
    endcase
  end

  assign o_seg = INVERT_OUTPUT ? ~w_seg : w_seg;

endmodule

// File: rtl/score_display_ctrl.sv
// Binary score to multi-digit 7-segment display: double-dabble conversion, then one
// shared decoder walks the digits into shadow registers that commit all at once.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SCORE_WIDTH   = 14,
  parameter bit          INVERT_OUTPUT = 1'b1,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    scoreValid,
  input  logic [SCORE_WIDTH-1:0]  score,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] segOut
);

  localparam int unsigned BcdW   = 4 * NUM_DIGITS;
  localparam int unsigned IdxW   = idx_width(NUM_DIGITS);
  localparam int unsigned CntW   = $clog2(SCORE_WIDTH + 1);
  localparam int unsigned MaxVal = max_value(NUM_DIGITS);
  localparam logic [6:0]  SegOff = INVERT_OUTPUT ? 7'h7F : 7'h00;

  state_e                   r_state;
  state_e                   w_state_nxt;
  logic [SCORE_WIDTH-1:0]   r_bin;
  logic [BcdW-1:0]          r_bcd;
  logic [CntW-1:0]          r_cnt;
  logic [IdxW-1:0]          r_idx;
  logic                     r_ovf_lat;
  logic                     r_pend_valid;
  logic [SCORE_WIDTH-1:0]   r_pend_score;
  logic [6:0]               r_shadow [NUM_DIGITS];

  logic                     w_commit;
  logic                     w_start;
  logic                     w_last_shift;
  logic [SCORE_WIDTH-1:0]   w_src;
  logic [31:0]              w_src_ext;
  logic                     w_src_ovf;
  logic [SCORE_WIDTH-1:0]   w_src_sat;
  logic [BcdW-1:0]          w_bcd_adj;
  logic [BcdW+SCORE_WIDTH-1:0] w_cat;
  logic [3:0]               w_nib;
  logic                     w_upper_zero;
  logic [6:0]               w_hex_seg;
  logic [6:0]               w_seg_sel;
  logic [6:0]               w_seg_fin;
  logic [7*NUM_DIGITS-1:0]  w_seg_commit;

  assign busy         = (r_state != StIdle);
  assign w_commit     = (r_state == StDecode) && (r_idx == IdxW'(NUM_DIGITS - 1));
  assign w_last_shift = (r_state == StConvert) && (r_cnt == CntW'(SCORE_WIDTH - 1));
  assign w_start      = ((r_state == StIdle) && scoreValid) ||
                        (w_commit && (scoreValid || r_pend_valid));

  // A fresh request always beats the pending one.
  assign w_src     = scoreValid ? score : r_pend_score;
  assign w_src_ext = 32'(w_src);
  assign w_src_ovf = (w_src_ext > MaxVal);
  assign w_src_sat = w_src_ovf ? SCORE_WIDTH'(MaxVal) : w_src;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:    if (scoreValid) w_state_nxt = StConvert;
      StConvert: if (w_last_shift) w_state_nxt = StDecode;
      StDecode:  if (w_commit) w_state_nxt = w_start ? StConvert : StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
    w_cat = {w_bcd_adj, r_bin} << 1;
  end

  always_comb begin
    w_nib        = 4'h0;
    w_upper_zero = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (k == int'(r_idx)) w_nib = r_bcd[4*k +: 4];
      if ((k >= int'(r_idx)) && (r_bcd[4*k +: 4] != 4'h0)) w_upper_zero = 1'b0;
    end
  end

  HexTo7Segment #(
    .INVERT_OUTPUT(1'b0)
  ) u_hex (
    .i_hex(w_nib),
    .o_seg(w_hex_seg)
  );

  assign w_seg_sel = (BLANK_LEADING && (r_idx != '0) && w_upper_zero) ? SEG_BLANK : w_hex_seg;
  assign w_seg_fin = INVERT_OUTPUT ? ~w_seg_sel : w_seg_sel;

  // The digit being decoded on the commit edge bypasses its shadow register.
  always_comb begin
    w_seg_commit = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      w_seg_commit[7*k +: 7] = (k == int'(r_idx)) ? w_seg_fin : r_shadow[k];
    end
  end

  always_ff @(posedge clock) begin
    if (r_state == StDecode) begin
      r_shadow[r_idx] <= w_seg_fin;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_ovf_lat    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_score <= '0;
      overflow     <= 1'b0;
      segOut       <= {NUM_DIGITS{SegOff}};
    end else begin
      r_state <= w_state_nxt;

      if (w_start) begin
        r_pend_valid <= 1'b0;
      end else if (scoreValid && (r_state != StIdle)) begin
        r_pend_valid <= 1'b1;
        r_pend_score <= score;
      end

      if (w_start) begin
        r_bin     <= w_src_sat;
        r_ovf_lat <= w_src_ovf;
        r_bcd     <= '0;
        r_cnt     <= '0;
      end else if (r_state == StConvert) begin
        r_bcd <= w_cat[BcdW+SCORE_WIDTH-1:SCORE_WIDTH];
        r_bin <= w_cat[SCORE_WIDTH-1:0];
        r_cnt <= r_cnt + CntW'(1);
        if (w_last_shift) r_idx <= '0;
      end else if (r_state == StDecode) begin
        r_idx <= r_idx + IdxW'(1);
      end

      if (w_commit) begin
        segOut   <= w_seg_commit;
        overflow <= r_ovf_lat;
      end
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Scoreboard bench for score_display_ctrl: stimulus queues expected commits with their
// due edge; a monitor checks every edge for either the due commit or a held value.
module tb_score_display_ctrl;

  logic        clock;
  logic        reset;
  logic        scoreValid;
  logic [13:0] score;
  logic        busy;
  logic        overflow;
  logic [27:0] segOut;

  score_display_ctrl #(
    .NUM_DIGITS(4),
    .SCORE_WIDTH(14),
    .INVERT_OUTPUT(1'b1),
    .BLANK_LEADING(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .scoreValid(scoreValid),
    .score(score),
    .busy(busy),
    .overflow(overflow),
    .segOut(segOut)
  );

  typedef struct {
    int          cyc;
    logic [27:0] seg;
    logic        ovf;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [27:0] cur_seg = 28'hFFFFFFF;
  logic        cur_ovf = 1'b0;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
  localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10, SB = 7'h7F;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [27:0] seg4(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one check per edge, 1 time unit after the rising edge.
  always @(posedge clock) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e = sb_q.pop_front();
        check("commit_seg", segOut, e.seg);
        check("commit_ovf", 28'(overflow), 28'(e.ovf));
        cur_seg = e.seg;
        cur_ovf = e.ovf;
      end else begin
        check("hold_seg", segOut, cur_seg);
        check("hold_ovf", 28'(overflow), 28'(cur_ovf));
      end
    end
  end

  // Called at a falling edge; the next rising edge accepts the score.
  task automatic send(input logic [13:0] v, input logic [27:0] seg, input logic ovf);
    scoreValid = 1'b1;
    score      = v;
    sb_q.push_back('{cyc: cyc + 19, seg: seg, ovf: ovf});
    @(negedge clock);
    scoreValid = 1'b0;
    check("busy_after_accept", 28'(busy), 28'd1);
    repeat (17) @(negedge clock);
    check("busy_before_commit", 28'(busy), 28'd1);
    @(negedge clock);
    check("busy_after_commit", 28'(busy), 28'd0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int a;
    reset      = 1'b0;
    scoreValid = 1'b0;
    score      = '0;
    repeat (3) @(negedge clock);
    check("reset_seg", segOut, 28'hFFFFFFF);
    check("reset_busy", 28'(busy), 28'd0);
    check("reset_ovf", 28'(overflow), 28'd0);
    cur_seg = 28'hFFFFFFF;
    cur_ovf = 1'b0;
    mon_en  = 1'b1;
    reset   = 1'b1;
    @(negedge clock);

    send(14'd0,     seg4(SB, SB, SB, S0), 1'b0);
    send(14'd1234,  seg4(S1, S2, S3, S4), 1'b0);
    send(14'd12000, seg4(S9, S9, S9, S9), 1'b1);
    send(14'd7,     seg4(SB, SB, SB, S7), 1'b0);
    send(14'd9999,  seg4(S9, S9, S9, S9), 1'b0);
    send(14'd10000, seg4(S9, S9, S9, S9), 1'b1);
    send(14'd100,   seg4(SB, S1, S0, S0), 1'b0);
    send(14'd16383, seg4(S9, S9, S9, S9), 1'b1);

    // Requests while busy: latest pending wins and restarts with no idle gap.
    scoreValid = 1'b1;
    score      = 14'd5;
    a = cyc + 1;
    sb_q.push_back('{cyc: a + 18, seg: seg4(SB, SB, SB, S5), ovf: 1'b0});
    sb_q.push_back('{cyc: a + 36, seg: seg4(SB, SB, SB, S8), ovf: 1'b0});
    for (int e = a; e <= a + 36; e++) begin
      @(negedge clock);
      scoreValid = (e == a + 2) || (e == a + 9);
      score      = (e == a + 2) ? 14'd7 : 14'd8;
      check("busy_restart", 28'(busy), (e < a + 36) ? 28'd1 : 28'd0);
    end
    scoreValid = 1'b0;
    repeat (2) @(negedge clock);

    // Reset in the middle of CONVERT aborts without a partial commit.
    scoreValid = 1'b1;
    score      = 14'd4321;
    a = cyc + 1;
    @(negedge clock);
    scoreValid = 1'b0;
    repeat (5) @(negedge clock);
    mon_en = 1'b0;
    reset  = 1'b0;
    repeat (2) @(negedge clock);
    check("abort_seg", segOut, 28'hFFFFFFF);
    check("abort_busy", 28'(busy), 28'd0);
    check("abort_ovf", 28'(overflow), 28'd0);
    cur_seg = 28'hFFFFFFF;
    cur_ovf = 1'b0;
    mon_en  = 1'b1;
    reset   = 1'b1;
    repeat (25) @(negedge clock);
    send(14'd42, seg4(SB, SB, S4, S2), 1'b0);

    repeat (3) @(negedge clock);
    check("queue_drained", 28'(sb_q.size()), 28'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
- Converts a binary score into decimal 7-segment codes for NUM_DIGITS displays on the Scoreboard.
- Runs an iterative shift-add-3 (double dabble) binary-to-BCD conversion.
- Time-shares one HexTo7Segment decoder across all digits, one digit per cycle, and commits every digit to the outputs at once, so no partial value is ever shown.
- Sits between the game-logic score counter and the board HEX pins.

Parameters:
- NUM_DIGITS, 4: number of decimal digits driven (1..6).
- SCORE_WIDTH, 14: width of the binary score input.
- INVERT_OUTPUT, 1: 1 means segments are active-low at the pins.
- BLANK_LEADING, 1: 1 means leading zeros are blanked. Digit 0 is never blanked.

Ports:
- clock, input, 1: system clock. All state changes on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- scoreValid, input, 1: update request, sampled every edge.
- score, input, SCORE_WIDTH: binary score. Sampled on the same edge as scoreValid.
- busy, output, 1: high while a conversion is in flight.
- overflow, output, 1: high when the last committed score exceeded 10^NUM_DIGITS-1.
- segOut, output, 7*NUM_DIGITS: segment codes. Digit k occupies bits [7k+6:7k]; digit 0 is least significant.

Behaviour:
- Reset (reset==0 at an edge) takes priority over everything:
  - state=IDLE; busy=0; overflow=0; pending flag cleared.
  - segOut = all segments off for every digit (28'hFFFFFFF when INVERT_OUTPUT=1, 0 otherwise).
  - Reset mid-conversion aborts the conversion; no partial commit.
- States: IDLE, CONVERT, DECODE.
- IDLE:
  - If scoreValid, latch the score, saturated to 10^NUM_DIGITS-1 when larger, and record the overflow condition.
  - Clear the BCD register and go to CONVERT; busy=1 from the same edge.
- CONVERT:
  - Exactly SCORE_WIDTH edges.
  - Each edge: every BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1.
  - BCD register width is 4*NUM_DIGITS.
  - After the last shift, go to DECODE with digit index 0.
- DECODE:
  - Exactly NUM_DIGITS edges. Digit index i feeds BCD nibble i to the single decoder instance.
  - Blanking: if BLANK_LEADING=1, i>0, and nibbles i..NUM_DIGITS-1 are all zero, store the blank code instead.
  - The result goes to shadow register i; inversion is applied in this block, and the decoder runs non-inverted.
  - On the edge for i=NUM_DIGITS-1: segOut <= shadow (including digit i) and overflow <= latched overflow. The block then returns to IDLE, or restarts (see below).
- Latency: segOut and overflow update exactly SCORE_WIDTH+NUM_DIGITS edges after the accepting edge (18 at defaults). busy falls on that same edge unless a restart occurs.
- Requests while busy:
  - One-deep pending buffer; the latest value wins.
  - Each scoreValid while busy overwrites the pending score and sets pending.
- Commit edge:
  - If scoreValid is high, accept it directly; it takes priority over pending, and pending is cleared.
  - Else if pending is set, start from pending.
  - Either way the state goes straight to CONVERT and busy stays high with no gap.
- Outputs stay constant between commits. No combinational path from inputs to outputs.

Decomposition:
- Shared package:
  - state encoding (IDLE/CONVERT/DECODE);
  - SEG_BLANK constant 7'b0000000 (pre-inversion);
  - max displayable value as a function of NUM_DIGITS (9, 99, ..., 999999);
  - digit-index width as clog2(NUM_DIGITS).
- No new sub-module. Instantiate the existing HexTo7Segment once, with INVERT_OUTPUT=0, as the shared decoder.

Test Plan (defaults: NUM_DIGITS=4, SCORE_WIDTH=14, INVERT_OUTPUT=1, BLANK_LEADING=1; codes listed digit 3..0):
1. Hold reset low 3 cycles, then release -> segOut=28'hFFFFFFF, busy=0, overflow=0.
2. score=0, scoreValid one cycle -> busy high for 18 edges, then segOut={7F,7F,7F,40}, overflow=0.
3. score=1234 -> after 18 edges segOut={79,24,30,19}. segOut holds its previous value at every edge before commit.
4. score=12000 -> segOut={10,10,10,10} (9999), overflow=1. A following score=7 -> {7F,7F,7F,78}, overflow=0.
5. score=5; while busy pulse score=7 at edge 3, then score=8 at edge 10 -> commit shows 5, restart is immediate with busy continuously high, and 18 edges later 8 is shown. 7 never appears.
6. score=4321 and assert reset at edge 6 of CONVERT -> segOut=28'hFFFFFFF, busy=0. After release, a new score=42 -> {7F,7F,19,24}.
